// File: rtl/lcd_spi_writer.sv
// rtl/lcd_spi_writer.sv - 9-bit command/data word to 4-wire SPI (mode 0) serialiser for the LCD panel
module lcd_spi_writer #(
    parameter int CLK_DIV = 2
) (
    input  logic       sys_clk_50MHz,
    input  logic       sys_rst_n,
    input  logic [8:0] data,
    input  logic       en_write,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       lcd_cs_n,
    output logic       wr_done,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [1:0]    state;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    // Bit 7 goes straight from the input to lcd_mosi, so only bits 6..0 are kept.
    logic [6:0]    shreg;

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            lcd_sclk <= 1'b0;
            lcd_mosi <= 1'b0;
            lcd_dc   <= 1'b0;
            lcd_cs_n <= 1'b1;
            wr_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    lcd_sclk <= 1'b0;
                    lcd_mosi <= 1'b0;
                    lcd_cs_n <= 1'b1;
                    busy     <= 1'b0;
                    if (en_write) begin
                        shreg    <= data[6:0];
                        lcd_dc   <= data[8];
                        lcd_mosi <= data[7];
                        lcd_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        lcd_sclk <= ~lcd_sclk;
                        // sclk currently high means this toggle is a falling edge
                        if (lcd_sclk) begin
                            if (bit_cnt == 3'd7) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                lcd_mosi <= shreg[6];
                                shreg    <= {shreg[5:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        lcd_cs_n <= 1'b1;
                        wr_done  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    lcd_mosi <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// tb/tb_lcd_spi_writer.sv - directed self-checking bench for lcd_spi_writer at CLK_DIV 2 and 1
module tb_lcd_spi_writer;

    logic       sys_clk_50MHz = 1'b0;
    logic       sys_rst_n     = 1'b0;
    logic [8:0] data_a = '0, data_b = '0;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic       sclk_a, mosi_a, dc_a, cs_n_a, done_a, busy_a;
    logic       sclk_b, mosi_b, dc_b, cs_n_b, done_b, busy_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         rise_a = 0, rise_b = 0, done_cnt_a = 0;
    logic [7:0] cap_a = '0, cap_b = '0;

    always #10 sys_clk_50MHz = ~sys_clk_50MHz;
    always @(posedge sys_clk_50MHz) cyc <= cyc + 1;
    always @(posedge sys_clk_50MHz) if (done_a) done_cnt_a <= done_cnt_a + 1;
    always @(posedge sclk_a) begin cap_a <= {cap_a[6:0], mosi_a}; rise_a <= rise_a + 1; end
    always @(posedge sclk_b) begin cap_b <= {cap_b[6:0], mosi_b}; rise_b <= rise_b + 1; end

    lcd_spi_writer #(.CLK_DIV(2)) u_a (
        .sys_clk_50MHz(sys_clk_50MHz), .sys_rst_n(sys_rst_n), .data(data_a), .en_write(en_a),
        .lcd_sclk(sclk_a), .lcd_mosi(mosi_a), .lcd_dc(dc_a), .lcd_cs_n(cs_n_a),
        .wr_done(done_a), .busy(busy_a)
    );

    lcd_spi_writer #(.CLK_DIV(1)) u_b (
        .sys_clk_50MHz(sys_clk_50MHz), .sys_rst_n(sys_rst_n), .data(data_b), .en_write(en_b),
        .lcd_sclk(sclk_b), .lcd_mosi(mosi_b), .lcd_dc(dc_b), .lcd_cs_n(cs_n_b),
        .wr_done(done_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (at negedges) for wr_done on instance A; returns cycle seen and CS-low cycles counted.
    task automatic wait_done_a(input string tag, output int at, output int low);
        at  = -1;
        low = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk_50MHz);
            if (cs_n_a == 1'b0) low++;
            if (done_a) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int e0, at, low, r0, d0, hi;
    int starts[3];
    int his[3];
    logic [7:0] words[3];
    logic       dcs[3];
    logic       prev_cs;
    logic       activity;

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk_50MHz);
        check("rst_cs_n_a", cs_n_a, 1);
        check("rst_outs_a", {sclk_a, mosi_a, dc_a, done_a, busy_a}, 0);
        check("rst_cs_n_b", cs_n_b, 1);
        check("rst_outs_b", {sclk_b, mosi_b, dc_b, done_b, busy_b}, 0);
        sys_rst_n = 1'b1;
        activity  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk_50MHz);
            if (!cs_n_a || !cs_n_b || sclk_a || sclk_b || done_a || done_b || busy_a || busy_b)
                activity = 1'b1;
        end
        check("idle_no_activity", {31'd0, activity}, 0);
        check("idle_no_rises", rise_a + rise_b, 0);

        // Single command 0x2A at D=2
        data_a = 9'h02A;
        en_a   = 1'b1;
        e0     = cyc + 1;
        r0     = rise_a;
        @(negedge sys_clk_50MHz);
        en_a = 1'b0;
        check("cmd_first_outs", {cs_n_a, dc_a, mosi_a, sclk_a, busy_a}, 5'b00001);
        low = 1;
        wait_done_a("cmd_done", at, d0);
        low = low + d0;
        check("cmd_done_lat", at - e0, 34);
        check("cmd_cs_low", low, 34);
        check("cmd_byte", cap_a, 8'h2A);
        check("cmd_rises", rise_a - r0, 8);
        check("cmd_dc", dc_a, 0);
        @(negedge sys_clk_50MHz);
        check("cmd_done_pulse", {done_a, busy_a, mosi_a, cs_n_a}, 4'b0001);

        // Data byte 0x1FF at D=1
        data_b = 9'h1FF;
        en_b   = 1'b1;
        e0     = cyc + 1;
        @(negedge sys_clk_50MHz);
        en_b = 1'b0;
        check("dat_first_outs", {cs_n_b, dc_b, mosi_b}, 3'b011);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            if (done_b) begin at = cyc; break; end
            @(negedge sys_clk_50MHz);
        end
        check("dat_done_lat", at - e0, 17);
        check("dat_busy_at_done", busy_b, 1);
        check("dat_byte", cap_b, 8'hFF);
        check("dat_rises", rise_b, 8);
        @(negedge sys_clk_50MHz);
        check("dat_busy_low", {busy_b, done_b}, 2'b00);
        check("dat_busy_lat", cyc - e0, 18);

        // Back-to-back streaming at D=2
        repeat (3) @(negedge sys_clk_50MHz);
        data_a  = 9'h011;
        en_a    = 1'b1;
        prev_cs = cs_n_a;
        hi      = 0;
        for (int w = 0; w < 3; w++) begin
            starts[w] = -1;
            for (int i = 0; i < 200; i++) begin
                @(negedge sys_clk_50MHz);
                if (cs_n_a) hi++;
                if (prev_cs && !cs_n_a && starts[w] < 0) begin
                    starts[w] = cyc;
                    his[w]    = hi;
                end
                prev_cs = cs_n_a;
                if (done_a) break;
            end
            words[w] = cap_a;
            dcs[w]   = dc_a;
            hi       = 0;
            data_a   = (w == 0) ? 9'h129 : 9'h1A5;
            if (w == 2) en_a = 1'b0;
        end
        check("b2b_word0", words[0], 8'h11);
        check("b2b_word1", words[1], 8'h29);
        check("b2b_word2", words[2], 8'hA5);
        check("b2b_dc", {dcs[0], dcs[1], dcs[2]}, 3'b011);
        check("b2b_space01", starts[1] - starts[0], 36);
        check("b2b_space12", starts[2] - starts[1], 36);
        check("b2b_cs_high1", {31'd0, his[1] >= 1}, 1);
        check("b2b_cs_high2", {31'd0, his[2] >= 1}, 1);

        // Interference mid-SHIFT
        repeat (4) @(negedge sys_clk_50MHz);
        d0     = done_cnt_a;
        r0     = rise_a;
        data_a = 9'h0C3;
        en_a   = 1'b1;
        @(negedge sys_clk_50MHz);
        en_a = 1'b0;
        repeat (10) @(negedge sys_clk_50MHz);
        data_a = 9'h13C;
        en_a   = 1'b1;
        @(negedge sys_clk_50MHz);
        en_a = 1'b0;
        wait_done_a("intf_done", at, low);
        check("intf_byte", cap_a, 8'hC3);
        check("intf_dc", dc_a, 0);
        repeat (40) @(negedge sys_clk_50MHz);
        check("intf_one_done", done_cnt_a - d0, 1);
        check("intf_rises", rise_a - r0, 8);

        // Reset in the middle of a transfer
        d0     = done_cnt_a;
        r0     = rise_a;
        data_a = 9'h0B7;
        en_a   = 1'b1;
        @(negedge sys_clk_50MHz);
        en_a = 1'b0;
        for (int i = 0; i < 100 && (rise_a - r0) < 4; i++) @(negedge sys_clk_50MHz);
        check("mid_reached_bit4", rise_a - r0, 4);
        @(negedge sys_clk_50MHz);
        check("mid_active", {cs_n_a, busy_a}, 2'b01);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {cs_n_a, sclk_a, busy_a, done_a, mosi_a, dc_a}, 6'b100000);
        repeat (3) @(negedge sys_clk_50MHz);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk_50MHz);
        check("mid_no_done", done_cnt_a - d0, 0);
        r0     = rise_a;
        data_a = 9'h05A;
        en_a   = 1'b1;
        @(negedge sys_clk_50MHz);
        en_a = 1'b0;
        wait_done_a("post_rst_done", at, low);
        check("post_rst_byte", cap_a, 8'h5A);
        check("post_rst_rises", rise_a - r0, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
